lstm_seq_ctrl: RTL and testbench

Sequencing controller for the LSTM forward-propagation array. On a `start` request it runs `NUM_ITERATIONS` timesteps. Each timestep does four things in order:
- shifts `NUM` input words into the input shift register;
- loads the storage register;
- waits for the LSTM datapath latency;
- latches the hidden state.

It drives the array's `sel`, `load` and `load_h` controls plus a shift enable. It reports progress and completion upstream to the training-loop control.

---
 rtl/lstm_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_lstm_seq_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lstm_seq_ctrl.sv
// Sequencing controller for the LSTM forward-propagation array: shift, load, compute, update
// per timestep. Optional abort support is enabled by defining LSTM_SEQ_ABORT_EN.
module lstm_seq_ctrl #(
  parameter int unsigned NUM            = 68,
  parameter int unsigned NUM_LSTM       = 8,
  parameter int unsigned NUM_ITERATIONS = 8,
  parameter int unsigned LSTM_LAT       = 4,
  localparam int unsigned SW = (NUM_ITERATIONS > 1) ? $clog2(NUM_ITERATIONS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          shift_en,
  output logic          load,
  output logic          sel,
  output logic          load_h,
  output logic          h_valid,
  output logic [SW-1:0] step,
  output logic          busy,
  output logic          done
);

  localparam int unsigned SCW = $clog2(NUM);
  localparam int unsigned LCW = (LSTM_LAT > 1) ? $clog2(LSTM_LAT) : 1;
  localparam logic [SCW-1:0] ShiftLast = SCW'(NUM - 1);
  localparam logic [LCW-1:0] LatLast   = LCW'(LSTM_LAT - 1);
  localparam logic [SW-1:0]  StepLast  = SW'(NUM_ITERATIONS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StLoad,
    StCompute,
    StUpdate,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [SCW-1:0] shift_cnt_q, shift_cnt_d;
  logic [LCW-1:0] lat_cnt_q, lat_cnt_d;
  logic [SW-1:0]  step_q, step_d;

`ifdef LSTM_SEQ_ABORT_EN
  logic unused_cfg;
  assign unused_cfg = ^NUM_LSTM;
`else
  logic unused_cfg;
  assign unused_cfg = abort ^ (^NUM_LSTM);
`endif

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    step_d      = step_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StShift;
          shift_cnt_d = '0;
          step_d      = '0;
        end
      end
      StShift: begin
        if (shift_cnt_q == ShiftLast) begin
          state_d     = StLoad;
          shift_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      StLoad: begin
        state_d   = StCompute;
        lat_cnt_d = '0;
      end
      StCompute: begin
        if (lat_cnt_q == LatLast) begin
          state_d   = StUpdate;
          lat_cnt_d = '0;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      StUpdate: begin
        if (step_q == StepLast) begin
          state_d = StDone;
        end else begin
          state_d = StShift;
          step_d  = step_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        step_d  = '0;
      end
      default: state_d = StIdle;
    endcase
`ifdef LSTM_SEQ_ABORT_EN
    // Abort overrides every transition, including the final UPDATE->DONE.
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      shift_cnt_d = '0;
      lat_cnt_d   = '0;
      step_d      = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      shift_cnt_q <= '0;
      lat_cnt_q   <= '0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      step_q      <= step_d;
    end
  end

  // Outputs are flopped from the next state so every output comes straight from a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_en <= 1'b0;
      load     <= 1'b0;
      sel      <= 1'b0;
      load_h   <= 1'b0;
      h_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      shift_en <= (state_d == StShift);
      load     <= (state_d == StLoad);
      sel      <= (step_d != '0);
      load_h   <= (state_d == StUpdate);
      h_valid  <= (state_d == StUpdate);
      busy     <= (state_d != StIdle);
      done     <= (state_d == StDone);
    end
  end

  assign step = step_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Self-checking bench for lstm_seq_ctrl with NUM=4, LSTM_LAT=2, NUM_ITERATIONS=3 (P=8).
module tb_lstm_seq_ctrl;

  localparam int unsigned Num     = 4;
  localparam int unsigned NumLstm = 8;
  localparam int unsigned NumIter = 3;
  localparam int unsigned Lat     = 2;
`ifdef LSTM_SEQ_ABORT_EN
  localparam bit AbortEn = 1'b1;
`else
  localparam bit AbortEn = 1'b0;
`endif

  logic       clk, rst, start, abort;
  logic       shift_en, load, sel, load_h, h_valid, busy, done;
  logic [1:0] step;

  lstm_seq_ctrl #(
    .NUM           (Num),
    .NUM_LSTM      (NumLstm),
    .NUM_ITERATIONS(NumIter),
    .LSTM_LAT      (Lat)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .shift_en(shift_en),
    .load    (load),
    .sel     (sel),
    .load_h  (load_h),
    .h_valid (h_valid),
    .step    (step),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {shift_en, load, sel, load_h, h_valid, busy, done, step[1:0]}
  typedef struct {
    int         cyc;
    logic [8:0] exp;
    bit         full;
  } vec_t;

  localparam logic [8:0] MaskAll  = 9'h1ff;
  localparam logic [8:0] MaskPart = 9'b1_1_0_1_1_1_1_00;

  vec_t vecs[17];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(int c, bit s, bit l, bit se, bit lh, bit b, bit d, int st, bit f);
    vec_t v;
    v.cyc  = c;
    v.exp  = {s, l, se, lh, lh, b, d, st[1:0]};
    v.full = f;
    return v;
  endfunction

  function automatic logic [8:0] act();
    return {shift_en, load, sel, load_h, h_valid, busy, done, step};
  endfunction

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] want,
                     input logic [8:0] mask);
    checks++;
    if ((got & mask) !== (want & mask)) begin
      errors++;
      $display("FAIL %s: got %b want %b (mask %b)", name, got, want, mask);
    end
  endtask

  task automatic check_cycle(input int n, input bit aborted);
    if (aborted && AbortEn && n >= 17) begin
      chk($sformatf("abort_c%0d", n), act(), 9'd0, MaskAll);
      return;
    end
    foreach (vecs[i]) begin
      if (vecs[i].cyc == n)
        chk($sformatf("c%0d", n), act(), vecs[i].exp, vecs[i].full ? MaskAll : MaskPart);
    end
  endtask

  // Entered #1 after a clock edge; start is sampled at edge 0, extra starts at e1/e2.
  task automatic run_seq(input int e1, input int e2, input int abort_cyc, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == e1) || (c == e2);
      abort = (c == abort_cyc);
      @(posedge clk);
      #1;
      check_cycle(c + 1, abort_cyc >= 0);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b0;
    #1;
    chk(name, act(), 9'd0, MaskAll);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_held"}, act(), 9'd0, MaskAll);
    rst = 1'b1;
  endtask

  initial begin
    //            cyc sh ld sel lh busy done step full
    vecs[0]  = mk(1,  1, 0, 0,  0, 1,   0,   0,   1);
    vecs[1]  = mk(4,  1, 0, 0,  0, 1,   0,   0,   1);
    vecs[2]  = mk(5,  0, 1, 0,  0, 1,   0,   0,   1);
    vecs[3]  = mk(6,  0, 0, 0,  0, 1,   0,   0,   1);
    vecs[4]  = mk(7,  0, 0, 0,  0, 1,   0,   0,   1);
    vecs[5]  = mk(8,  0, 0, 0,  1, 1,   0,   0,   1);
    vecs[6]  = mk(9,  1, 0, 1,  0, 1,   0,   1,   1);
    vecs[7]  = mk(12, 1, 0, 1,  0, 1,   0,   1,   1);
    vecs[8]  = mk(13, 0, 1, 1,  0, 1,   0,   1,   1);
    vecs[9]  = mk(16, 0, 0, 1,  1, 1,   0,   1,   1);
    vecs[10] = mk(17, 1, 0, 1,  0, 1,   0,   2,   1);
    vecs[11] = mk(20, 1, 0, 1,  0, 1,   0,   2,   1);
    vecs[12] = mk(21, 0, 1, 1,  0, 1,   0,   2,   1);
    vecs[13] = mk(23, 0, 0, 1,  0, 1,   0,   2,   1);
    vecs[14] = mk(24, 0, 0, 1,  1, 1,   0,   2,   1);
    vecs[15] = mk(25, 0, 0, 0,  0, 1,   1,   0,   0);
    vecs[16] = mk(26, 0, 0, 0,  0, 0,   0,   0,   1);

    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("reset", act(), 9'd0, MaskAll);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle", act(), 9'd0, MaskAll);

    // Nominal sequence
    run_seq(-1, -1, -1, 26);

    // Starts while busy are ignored; a start in cycle 26 begins a new sequence
    run_seq(3, 20, -1, 26);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart_c27", act(), 9'b1_0_0_0_0_1_0_00, MaskAll);
    do_reset("reset_restart");

    // Asynchronous reset mid-sequence, then a clean restart
    run_seq(-1, -1, -1, 14);
    chk("pre_reset_busy", act(), 9'b0_0_1_0_0_1_0_01, MaskAll);
    do_reset("reset_mid");
    run_seq(-1, -1, -1, 26);

    // Abort during UPDATE of step 1 (ignored unless the abort build is selected)
    run_seq(-1, -1, 16, 26);
    repeat (2) @(posedge clk);
    #1;
    chk("final_idle", act(), 9'd0, MaskAll);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
